// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 frame receiver with E0/F0 prefix folding and an FWFT key-event queue
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_Clock,
  input  logic       iPS2_Data,
  input  logic       iRead,
  output logic       oKey_Valid,
  output logic [7:0] oKey_Code,
  output logic       oKey_Release,
  output logic       oKey_Extended,
  output logic       oFrame_Error,
  output logic       oOverflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          state, stateNext;
  logic [1:0]      clkSync, datSync;
  logic            clkPrev, ps2Edge, ps2Bit, frameOk, timeout;
  logic [2:0]      bitCnt;
  logic [7:0]      shiftReg;
  logic            parityBit, byteGood, frameErr, extFlag, relFlag;
  logic            isE0, isF0, push, pop, wrEn, full, empty, overflow;
  logic [TW-1:0]   quietCnt;
  logic [AW:0]     wrPtr, rdPtr;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [9:0]      head;
  assign ps2Edge = clkPrev & ~clkSync[1];
  assign ps2Bit  = datSync[1];
  assign frameOk = ps2Bit & (^{shiftReg, parityBit});
  assign timeout = (state != IDLE) && !ps2Edge && (quietCnt == TW'(TIMEOUT_CYCLES - 1));
  assign isE0    = shiftReg == 8'hE0;
  assign isF0    = shiftReg == 8'hF0;
  assign push    = byteGood && !isE0 && !isF0;
  assign empty   = wrPtr == rdPtr;
  assign full    = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
  assign pop     = iRead && !empty;
  assign wrEn    = push && (!full || pop);
  assign head    = empty ? '0 : mem[rdPtr[AW-1:0]];
  assign oKey_Valid    = !empty;
  assign oKey_Code     = head[7:0];
  assign oKey_Release  = head[8];
  assign oKey_Extended = head[9];
  assign oFrame_Error  = frameErr;
  assign oOverflow     = overflow;
  // Two-stage synchronizers; idle-high reset values avoid a false edge after reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
      clkPrev <= 1'b1;
    end else begin
      clkSync <= {clkSync[0], iPS2_Clock};
      datSync <= {datSync[0], iPS2_Data};
      clkPrev <= clkSync[1];
    end
  end
  // Frame state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else state <= stateNext;
  end
  // Frame next-state: advance one step per PS/2 falling edge, abandon on timeout
  always_comb begin
    stateNext = state;
    if (timeout) stateNext = IDLE;
    else if (ps2Edge)
      case (state)
        IDLE:    stateNext = ps2Bit ? IDLE : DATA;
        DATA:    stateNext = (bitCnt == 3'd7) ? PARITY : DATA;
        PARITY:  stateNext = STOP;
        default: stateNext = IDLE;
      endcase
  end
  // Bit shifting, frame check strobes and the inactivity counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      byteGood  <= 1'b0;
      frameErr  <= 1'b0;
      quietCnt  <= '0;
    end else begin
      if (ps2Edge && state == IDLE) bitCnt <= '0;
      if (ps2Edge && state == DATA) begin
        shiftReg <= {ps2Bit, shiftReg[7:1]};
        bitCnt   <= bitCnt + 3'd1;
      end
      if (ps2Edge && state == PARITY) parityBit <= ps2Bit;
      byteGood <= ps2Edge && state == STOP && frameOk;
      frameErr <= timeout || (ps2Edge && state == STOP && !frameOk);
      quietCnt <= (ps2Edge || state == IDLE) ? '0 : quietCnt + TW'(1);
    end
  end
  // Prefix flags: E0/F0 accumulate, any other good byte or a rejected frame clears them
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      extFlag <= 1'b0;
      relFlag <= 1'b0;
    end else if (frameErr) begin
      extFlag <= 1'b0;
      relFlag <= 1'b0;
    end else if (byteGood) begin
      extFlag <= isE0 | (extFlag & isF0);
      relFlag <= isF0 | (relFlag & isE0);
    end
  end
  // Queue pointers and sticky overflow; a pop frees the slot a same-cycle push needs when full
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      wrPtr    <= wrPtr + (AW+1)'(wrEn);
      rdPtr    <= rdPtr + (AW+1)'(pop);
      overflow <= overflow | (push & full & !pop);
    end
  end
  // Event storage
  always_ff @(posedge Clock) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= {extFlag, relFlag, shiftReg};
  end
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed vectors, corner sequences and randomized frames against a queue model
module tb_ps2_key_event_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 5000;
  localparam int HALF  = 10;
  logic       Clock = 1'b0, Reset = 1'b0, iPS2_Clock = 1'b1, iPS2_Data = 1'b1, iRead = 1'b0;
  logic       oKey_Valid, oKey_Release, oKey_Extended, oFrame_Error, oOverflow;
  logic [7:0] oKey_Code;
  int checks = 0, errors = 0, errCnt = 0, widePulses = 0;
  logic errPrev = 1'b0;
  logic [9:0] q[$];
  logic mExt = 1'b0, mRel = 1'b0, mOvf = 1'b0;
  int mErr = 0;
  typedef struct {
    logic [7:0] data;
    logic       badPar;
    logic       doPop;
    logic       expValid;
    logic [7:0] expCode;
    logic       expRel;
    logic       expExt;
  } vec_t;
  vec_t vecs[11];

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .iPS2_Clock(iPS2_Clock), .iPS2_Data(iPS2_Data), .iRead(iRead),
    .oKey_Valid(oKey_Valid), .oKey_Code(oKey_Code), .oKey_Release(oKey_Release),
    .oKey_Extended(oKey_Extended), .oFrame_Error(oFrame_Error), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oFrame_Error) begin
      errCnt++;
      if (errPrev) widePulses++;
    end
    errPrev = oFrame_Error;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic goodPar(input logic [7:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  function automatic void modelFrame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop || ($countones({d, par}) % 2 != 1)) begin
      mErr++;
      mExt = 1'b0;
      mRel = 1'b0;
    end else if (d == 8'hE0) mExt = 1'b1;
    else if (d == 8'hF0) mRel = 1'b1;
    else begin
      if (q.size() < DEPTH) q.push_back({mExt, mRel, d});
      else mOvf = 1'b1;
      mExt = 1'b0;
      mRel = 1'b0;
    end
  endfunction

  task automatic ps2Bit(input logic b);
    iPS2_Data = b;
    repeat (HALF) @(negedge Clock);
    iPS2_Clock = 1'b0;
    repeat (HALF) @(negedge Clock);
    iPS2_Clock = 1'b1;
  endtask

  task automatic sendHead(input logic [7:0] d, input logic par);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit(par);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop);
    sendHead(d, par);
    ps2Bit(stop);
    modelFrame(d, par, stop);
  endtask

  task automatic popOne();
    iRead = 1'b1;
    @(negedge Clock);
    iRead = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic compareModel(input string tag);
    logic [9:0] h;
    h = (q.size() != 0) ? q[0] : 10'h0;
    check({tag, "_valid"}, 32'(oKey_Valid), 32'(q.size() != 0));
    check({tag, "_code"}, 32'(oKey_Code), 32'(h[7:0]));
    check({tag, "_rel"}, 32'(oKey_Release), 32'(h[8]));
    check({tag, "_ext"}, 32'(oKey_Extended), 32'(h[9]));
    check({tag, "_ovf"}, 32'(oOverflow), 32'(mOvf));
    check({tag, "_errs"}, 32'(errCnt), 32'(mErr));
  endtask

  initial begin
    logic [7:0] expOrder [4];
    int waited;
    bit seen;
    vecs[0]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0};
    vecs[2]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h29, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'h29, 1'b0, 1'b1, 1'b1, 8'h29, 1'b0, 1'b0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
    expOrder[0] = 8'h22; expOrder[1] = 8'h33; expOrder[2] = 8'h44; expOrder[3] = 8'h66;
    repeat (3) @(negedge Clock);
    check("rst_valid", 32'(oKey_Valid), 0);
    check("rst_code", 32'(oKey_Code), 0);
    check("rst_rel", 32'(oKey_Release), 0);
    check("rst_ext", 32'(oKey_Extended), 0);
    check("rst_ferr", 32'(oFrame_Error), 0);
    check("rst_ovf", 32'(oOverflow), 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    sendHead(8'h1C, 1'b0);
    iPS2_Data = 1'b1;
    repeat (HALF) @(negedge Clock);
    iPS2_Clock = 1'b0;
    repeat (3) @(negedge Clock);
    check("make_valid_n1", 32'(oKey_Valid), 0);
    @(negedge Clock);
    check("make_valid_n2", 32'(oKey_Valid), 1);
    check("make_code_n2", 32'(oKey_Code), 32'h1C);
    check("make_rel_n2", 32'(oKey_Release), 0);
    check("make_ext_n2", 32'(oKey_Extended), 0);
    repeat (HALF - 4) @(negedge Clock);
    iPS2_Clock = 1'b1;
    modelFrame(8'h1C, 1'b0, 1'b1);
    popOne();
    check("make_pop_valid", 32'(oKey_Valid), 0);
    for (int i = 0; i < 11; i++) begin
      sendFrame(vecs[i].data, goodPar(vecs[i].data) ^ vecs[i].badPar, 1'b1);
      check($sformatf("vec%0d_valid", i), 32'(oKey_Valid), 32'(vecs[i].expValid));
      check($sformatf("vec%0d_code", i), 32'(oKey_Code), 32'(vecs[i].expCode));
      check($sformatf("vec%0d_rel", i), 32'(oKey_Release), 32'(vecs[i].expRel));
      check($sformatf("vec%0d_ext", i), 32'(oKey_Extended), 32'(vecs[i].expExt));
      if (vecs[i].doPop) popOne();
    end
    check("vec_err_pulses", 32'(errCnt), 2);
    compareModel("after_vecs");
    popOne();
    compareModel("pop_empty");
    for (int i = 1; i <= DEPTH + 1; i++) sendFrame(8'(i * 8'h11), goodPar(8'(i * 8'h11)), 1'b1);
    check("ovf_flag", 32'(oOverflow), 1);
    check("ovf_head", 32'(oKey_Code), 32'h11);
    compareModel("ovf");
    sendHead(8'h66, goodPar(8'h66));
    iPS2_Data = 1'b1;
    repeat (HALF) @(negedge Clock);
    iPS2_Clock = 1'b0;
    repeat (3) @(negedge Clock);
    iRead = 1'b1;
    @(negedge Clock);
    iRead = 1'b0;
    repeat (HALF - 4) @(negedge Clock);
    iPS2_Clock = 1'b1;
    void'(q.pop_front());
    q.push_back({2'b00, 8'h66});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_rw_valid%0d", i), 32'(oKey_Valid), 1);
      check($sformatf("full_rw_code%0d", i), 32'(oKey_Code), 32'(expOrder[i]));
      popOne();
    end
    check("full_rw_drained", 32'(oKey_Valid), 0);
    sendFrame(8'hF0, 1'b1, 1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1); ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b1);
    seen = 0;
    waited = 0;
    for (int c = 0; c < TMO + 200 && !seen; c++) begin
      @(negedge Clock);
      waited++;
      if (oFrame_Error) seen = 1;
    end
    check("timeout_seen", 32'(seen), 1);
    check("timeout_latency", 32'(waited >= TMO - 30 && waited <= TMO + 10), 1);
    mErr++;
    mExt = 1'b0;
    mRel = 1'b0;
    repeat (5) @(negedge Clock);
    sendFrame(8'h5A, goodPar(8'h5A), 1'b1);
    check("timeout_next_code", 32'(oKey_Code), 32'h5A);
    check("timeout_next_rel", 32'(oKey_Release), 0);
    compareModel("timeout");
    sendFrame(8'h33, goodPar(8'h33), 1'b1);
    sendFrame(8'hE0, 1'b0, 1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("rstmid_valid", 32'(oKey_Valid), 0);
    check("rstmid_code", 32'(oKey_Code), 0);
    check("rstmid_rel", 32'(oKey_Release), 0);
    check("rstmid_ext", 32'(oKey_Extended), 0);
    check("rstmid_ferr", 32'(oFrame_Error), 0);
    check("rstmid_ovf", 32'(oOverflow), 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    q.delete();
    mExt = 1'b0;
    mRel = 1'b0;
    mOvf = 1'b0;
    repeat (2) @(negedge Clock);
    sendFrame(8'h1C, 1'b0, 1'b1);
    check("rstmid_next_ext", 32'(oKey_Extended), 0);
    compareModel("after_reset");
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      int sel;
      if ($urandom_range(0, 9) < 3) popOne();
      else begin
        sel = $urandom_range(0, 5);
        d = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
        sendFrame(d, goodPar(d) ^ ($urandom_range(0, 7) == 0), $urandom_range(0, 15) != 0);
      end
      compareModel($sformatf("rnd%0d", n));
    end
    check("err_pulse_width", 32'(widePulses), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Receives PS/2 keyboard frames, validates them, folds E0/F0 prefix bytes into single key events, and queues those events in a small first-word-fall-through (FWFT) FIFO. It is the sequencing and control stage between the keyboard pins and the VGA controller: the display side pops one complete key event at a time and never sees raw scan-code bytes.

## Interface
- FIFO_DEPTH, 4: event queue depth; power of two, at least 2.
- TIMEOUT_CYCLES, 5000: Clock cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- Clock  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-low; assert with Reset = 0.
- iPS2_Clock  in  1  raw keyboard clock, asynchronous to Clock.
- iPS2_Data  in  1  raw keyboard data, asynchronous to Clock.
- iRead  in  1  pop the head event; ignored when the FIFO is empty.
- oKey_Valid  out  1  FIFO is non-empty; head event is presented on the outputs below.
- oKey_Code  out  8  head event scan code.
- oKey_Release  out  1  head event is a key release (F0 was seen).
- oKey_Extended  out  1  head event is extended (E0 was seen).
- oFrame_Error  out  1  one-cycle pulse when a frame is rejected.
- oOverflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- **Input sync.** iPS2_Clock and iPS2_Data each pass through 2 flip-flops. A falling edge is detected when the previous synced clock sample is 1 and the current one is 0. Data is sampled on that edge.
- **Frame FSM.**
  - IDLE: on an edge with data 0 (start bit), go to DATA with bit count 0. An edge with data 1 is ignored.
  - DATA: shift data in LSB first. After 8 edges, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: check the frame, then go to IDLE.
- **Frame check.** A frame is good when the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones. Otherwise pulse oFrame_Error, discard the byte, and clear both prefix flags.
- **Timeout.** A counter clears on every edge. If it reaches TIMEOUT_CYCLES in any state other than IDLE, return to IDLE, pulse oFrame_Error, and clear the prefix flags. In IDLE the counter does not raise an error.
- **Prefix decode (good bytes only).**
  - E0 sets ext_flag.
  - F0 sets rel_flag.
  - Any other byte pushes {ext_flag, rel_flag, byte} into the FIFO, then clears both flags.
  - The sequence E0 F0 code yields a single event with Extended = 1 and Release = 1.
- **FIFO.** 10-bit entries; read and write pointers use one extra bit to tell full from empty.
  - Outputs always show the head entry. They read 0 when the FIFO is empty.
  - Push when full, with iRead = 0: the event is dropped and oOverflow is set to 1. oOverflow clears only on reset.
  - Push and pop in the same cycle are both accepted at any occupancy, including full. Occupancy is unchanged.
  - Pop when empty does nothing.
- **Reset mid-frame or mid-prefix.** All state is cleared: FSM to IDLE, prefix flags cleared, FIFO empty, oOverflow = 0.

## Timing
- Reset values: oKey_Valid = 0, oKey_Code = 0x00, oKey_Release = 0, oKey_Extended = 0, oFrame_Error = 0, oOverflow = 0.
- A pin transition is seen by the edge detector 2 cycles later; the edge pulse is 1 cycle wide.
- The stop-bit edge pulse occurs in cycle N:
  - FIFO write (or oFrame_Error pulse) happens in cycle N+1.
  - If the FIFO was empty, oKey_Valid = 1 and the event appears on the outputs in cycle N+2.
- iRead sampled high at rising edge K: the next entry, or oKey_Valid = 0, is visible after edge K. Sustained iRead pops one entry per cycle.
- The design requires at least 8 Clock cycles per PS/2 half-period. At the 2-cycle stimulus rate, the bench drives the PS/2 pins on a divided clock.
- oFrame_Error lasts exactly 1 cycle per rejected frame.

## Test plan
- **Make code.** Send a frame with byte 0x1C and parity 0 -> one event: Code = 0x1C, Release = 0, Extended = 0, oKey_Valid = 1 at N+2. Pop -> oKey_Valid = 0.
- **Break sequence.** Send F0 (parity 1), then 0x1C -> exactly one event: Code = 0x1C, Release = 1. No event is produced for F0.
- **Extended release.** Send E0 (parity 0), F0, 0x75 (parity 0) -> one event: Code = 0x75, Extended = 1, Release = 1.
- **Parity error.** Send 0x29 with parity 1 -> oFrame_Error pulses once and no event is queued. A following good 0x29 -> event with Release = 0, even if F0 preceded the bad frame.
- **Overflow.** Queue FIFO_DEPTH + 1 events with no reads -> the first 4 codes are kept in order and oOverflow = 1. Then pop and push in the same cycle while full -> both accepted, occupancy stays 4.
- **Timeout and reset.** Stop the PS/2 clock after 4 data bits -> after TIMEOUT_CYCLES, oFrame_Error pulses and the FSM returns to IDLE; the next full frame decodes correctly. Separately, drive Reset = 0 mid-frame -> all outputs return to their reset values immediately.
